// File: rtl/writeback_stage_if.sv
// writeback_stage_if
//   Bundles the memory-stage-to-writeback signals and the writeback
//   results into one interface.
//   master : memory stage / environment side (drives instruction fields and
//            the data-memory response, observes stall and the write port).
//   slave  : writeback stage side.
//   Signals:
//     in_valid, alu_out_wb[31:0], rd_addr[4:0], reg_write, wb_mux[1:0],
//     funct3[2:0], pc[31:0], dmem_rdata[31:0], dmem_rvalid  (to writeback)
//     stall, rf_we, rf_waddr[4:0], rf_wdata[31:0], retire, load_fault
//                                                            (from writeback)
interface writeback_stage_if;
  logic        in_valid;
  logic [31:0] alu_out_wb;
  logic [4:0]  rd_addr;
  logic        reg_write;
  logic [1:0]  wb_mux;
  logic [2:0]  funct3;
  logic [31:0] pc;
  logic [31:0] dmem_rdata;
  logic        dmem_rvalid;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        retire;
  logic        load_fault;

  modport master (
    output in_valid, alu_out_wb, rd_addr, reg_write, wb_mux, funct3, pc,
           dmem_rdata, dmem_rvalid,
    input  stall, rf_we, rf_waddr, rf_wdata, retire, load_fault
  );

  modport slave (
    input  in_valid, alu_out_wb, rd_addr, reg_write, wb_mux, funct3, pc,
           dmem_rdata, dmem_rvalid,
    output stall, rf_we, rf_waddr, rf_wdata, retire, load_fault
  );
endinterface

// File: rtl/writeback_stage.sv
// writeback_stage
//   Final pipeline stage. Aligns/extends load data, selects the write-back
//   source and drives the register-file write port one cycle later. A small
//   FSM holds a load whose data has not arrived and raises stall meanwhile.
//   Ports:
//     clk, rst        : clock, synchronous active-high reset
//     wb (slave)      : instruction fields, dmem response, stall and the
//                       registered write port / retire / load_fault pulses
//     perf_retired, perf_load_stall : only when WB_PERF_COUNT_EN is defined
//   Optional feature macro: WB_PERF_COUNT_EN (performance counters).
//
//   state  | meaning
//   IDLE   | accepting instructions from the memory stage
//   WAIT   | load captured, waiting for dmem_rvalid or timeout
module writeback_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int PERF_WIDTH     = 32
) (
  input  logic clk,
  input  logic rst,
  writeback_stage_if.slave wb
`ifdef WB_PERF_COUNT_EN
  ,
  output logic [PERF_WIDTH-1:0] perf_retired,
  output logic [PERF_WIDTH-1:0] perf_load_stall
`endif
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // The timeout fires on the WAIT cycle whose increment would reach the limit.
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  logic [0:0]       state;
  logic [CNT_W-1:0] to_cnt;
  logic [4:0]       cap_rd;
  logic             cap_rw;
  logic [2:0]       cap_f3;
  logic [1:0]       cap_off;

  logic        rf_we_q;
  logic [4:0]  rf_waddr_q;
  logic [31:0] rf_wdata_q;
  logic        retire_q;
  logic        fault_q;

  logic        is_load;
  logic        stall_c;
  logic        timeout_hit;
  logic [31:0] ld_now;
  logic [31:0] ld_wait;
  logic [31:0] src_now;

  // Halfword lane uses off[1] only; off[0] is deliberately ignored.
  function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                               input logic [1:0]  off,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {off, 3'b000});
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_extract = {{24{b[7]}}, b};
      3'b001:  load_extract = {{16{h[15]}}, h};
      3'b100:  load_extract = {24'b0, b};
      3'b101:  load_extract = {16'b0, h};
      default: load_extract = w;
    endcase
  endfunction

  always_comb begin
    is_load     = wb.in_valid && (wb.wb_mux == 2'b01);
    stall_c     = ((state == S_IDLE) && is_load && !wb.dmem_rvalid) ||
                  ((state == S_WAIT) && !wb.dmem_rvalid);
    timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);
    ld_now      = load_extract(wb.funct3, wb.alu_out_wb[1:0], wb.dmem_rdata);
    ld_wait     = load_extract(cap_f3, cap_off, wb.dmem_rdata);
    case (wb.wb_mux)
      2'b01:   src_now = ld_now;
      2'b10:   src_now = wb.pc + 32'd4;
      default: src_now = wb.alu_out_wb;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      to_cnt     <= '0;
      cap_rd     <= '0;
      cap_rw     <= 1'b0;
      cap_f3     <= '0;
      cap_off    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      retire_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      rf_we_q  <= 1'b0;
      retire_q <= 1'b0;
      fault_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (wb.in_valid) begin
            if (!is_load || wb.dmem_rvalid) begin
              retire_q <= 1'b1;
              if (wb.reg_write && (wb.rd_addr != 5'd0)) begin
                rf_we_q    <= 1'b1;
                rf_waddr_q <= wb.rd_addr;
                rf_wdata_q <= src_now;
              end
            end else begin
              cap_rd  <= wb.rd_addr;
              cap_rw  <= wb.reg_write;
              cap_f3  <= wb.funct3;
              cap_off <= wb.alu_out_wb[1:0];
              to_cnt  <= '0;
              state   <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (wb.dmem_rvalid) begin
            retire_q <= 1'b1;
            if (cap_rw && (cap_rd != 5'd0)) begin
              rf_we_q    <= 1'b1;
              rf_waddr_q <= cap_rd;
              rf_wdata_q <= ld_wait;
            end
            to_cnt <= '0;
            state  <= S_IDLE;
          end else if (timeout_hit) begin
            fault_q <= 1'b1;
            to_cnt  <= '0;
            state   <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef WB_PERF_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_retired    <= '0;
      perf_load_stall <= '0;
    end else begin
      if (retire_q) perf_retired    <= perf_retired + 1'b1;
      if (stall_c)  perf_load_stall <= perf_load_stall + 1'b1;
    end
  end
`endif

  assign wb.stall      = stall_c;
  assign wb.rf_we      = rf_we_q;
  assign wb.rf_waddr   = rf_waddr_q;
  assign wb.rf_wdata   = rf_wdata_q;
  assign wb.retire     = retire_q;
  assign wb.load_fault = fault_q;

endmodule
